// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters, with a tag pipe
// and one-entry response buffer per requester. `define MSA_PERF_CNT_EN adds ops_done/stall_cycles.

module msa_lane #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               grant_i,
  input  logic               cap_i,
  input  logic               drop_i,
  input  logic               ack_i,
  input  logic [2*WIDTH-1:0] res_i,
  output logic               busy_o,
  output logic               rsp_valid_o,
  output logic [2*WIDTH-1:0] rsp_data_o
);
  logic               busy_q, busy_d, vld_q, vld_d, done;
  logic [2*WIDTH-1:0] data_q, data_d;

  always_comb begin
    done   = vld_q & ack_i;
    busy_d = busy_q;
    vld_d  = vld_q;
    data_d = data_q;
    if (grant_i)              busy_d = 1'b1;
    else if (done || drop_i)  busy_d = 1'b0;
    if (cap_i) begin
      vld_d  = 1'b1;
      data_d = res_i;
    end else if (done) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign busy_o      = busy_q;
  assign rsp_valid_o = vld_q;
  assign rsp_data_o  = data_q;
endmodule

module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int LATENCY = 4,
  parameter int TAG_W   = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [NUM_REQ*2*WIDTH-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]         rsp_ack,
  output logic                       mul_data_rdy,
  output logic [WIDTH-1:0]           mul_mult1,
  output logic [WIDTH-1:0]           mul_mult2,
  input  logic                       mul_res_rdy,
  input  logic [2*WIDTH-1:0]         mul_res,
`ifdef MSA_PERF_CNT_EN
  output logic [15:0]                ops_done,
  output logic [15:0]                stall_cycles,
`endif
  output logic                       err
);
  localparam int STAGES = LATENCY;

  logic [NUM_REQ-1:0]              busy, elig, gnt, cap_vec, drop_vec;
  logic [TAG_W-1:0]                ptr_q, ptr_d, gnt_idx, tail_tag;
  logic [TAG_W:0]                  cand;
  // Stage 0 is the issue register itself; stage STAGES lines up with mul_res_rdy.
  logic [STAGES:0]                 vld_pipe_q, ghost_q;
  logic [STAGES:0][TAG_W-1:0]      tag_pipe_q;
  logic [WIDTH-1:0]                m1_q, m2_q;
  logic                            err_q, err_d;
  logic                            tail_v, stale, cap, drop, spurious;

  assign elig = req_valid & ~busy;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (TAG_W+1)'(k);
      if (cand >= (TAG_W+1)'(NUM_REQ)) cand = cand - (TAG_W+1)'(NUM_REQ);
      if (!rstn && gnt == '0 && elig[cand[TAG_W-1:0]]) begin
        gnt[cand[TAG_W-1:0]] = 1'b1;
        gnt_idx              = cand[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt != '0)
      ptr_d = (gnt_idx == TAG_W'(NUM_REQ-1)) ? '0 : gnt_idx + TAG_W'(1);
  end

  assign tail_v   = vld_pipe_q[STAGES];
  assign tail_tag = tag_pipe_q[STAGES];
  assign stale    = ghost_q[STAGES];
  assign cap      = tail_v & mul_res_rdy;
  assign drop     = tail_v & ~mul_res_rdy;
  assign spurious = mul_res_rdy & ~tail_v & ~stale;
  assign err_d    = err_q | drop | spurious;

  always_ff @(posedge clk) begin
    // Shadow of operations discarded by reset, so their late results are ignored silently.
    ghost_q[0] <= 1'b0;
    for (int k = 1; k <= STAGES; k++)
      ghost_q[k] <= ghost_q[k-1] | (rstn & vld_pipe_q[k-1]);
    if (rstn) begin
      ptr_q      <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], |gnt};
      tag_pipe_q <= {tag_pipe_q[STAGES-1:0], gnt_idx};
      if (gnt != '0) begin
        m1_q <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        m2_q <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign cap_vec[i]  = cap  && (tail_tag == TAG_W'(i));
    assign drop_vec[i] = drop && (tail_tag == TAG_W'(i));
    msa_lane #(.WIDTH(WIDTH)) u_lane (
      .clk         (clk),
      .rstn        (rstn),
      .grant_i     (gnt[i]),
      .cap_i       (cap_vec[i]),
      .drop_i      (drop_vec[i]),
      .ack_i       (rsp_ack[i]),
      .res_i       (mul_res),
      .busy_o      (busy[i]),
      .rsp_valid_o (rsp_valid[i]),
      .rsp_data_o  (rsp_data[i*2*WIDTH +: 2*WIDTH])
    );
  end

  assign req_ready    = gnt;
  assign mul_data_rdy = vld_pipe_q[0];
  assign mul_mult1    = m1_q;
  assign mul_mult2    = m2_q;
  assign err          = err_q;

`ifdef MSA_PERF_CNT_EN
  logic [15:0] ops_q, stall_q;
  always_ff @(posedge clk) begin
    if (rstn) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (cap) ops_q <= ops_q + 16'd1;
      if (req_valid != '0 && gnt == '0 && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end
  assign ops_done     = ops_q;
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural LATENCY-cycle multiplier.
module tb_mult_share_arbiter;
  localparam int N = 4, W = 4, LAT = 4, TW = 2;

  logic             clk = 1'b0, rstn = 1'b1;
  logic [N-1:0]     req_valid = '0, rsp_ack = '0, req_ready, rsp_valid;
  logic [N*W-1:0]   req_a = '0, req_b = '0;
  logic [N*2*W-1:0] rsp_data;
  logic             mul_data_rdy, mul_res_rdy, err;
  logic [W-1:0]     mul_mult1, mul_mult2;
  logic [2*W-1:0]   mul_res;
  logic             force_rdy = 1'b0, model_en = 1'b1;
  logic [LAT-1:0]   mv = '0;
  logic [2*W-1:0]   mp [LAT];
  wire  [2*W-1:0]   prod = {{W{1'b0}}, mul_mult1} * {{W{1'b0}}, mul_mult2};
  int               n_vec = 0, n_err = 0;
  logic [N-1:0]     exp_v;
`ifdef MSA_PERF_CNT_EN
  logic [15:0]      ops_done, stall_cycles;
`endif

  mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
    .mul_data_rdy(mul_data_rdy), .mul_mult1(mul_mult1), .mul_mult2(mul_mult2),
    .mul_res_rdy(mul_res_rdy), .mul_res(mul_res),
`ifdef MSA_PERF_CNT_EN
    .ops_done(ops_done), .stall_cycles(stall_cycles),
`endif
    .err(err));

  always #5 clk = ~clk;

  // Multiplier model: not reset, so results of discarded operations still come back.
  always @(posedge clk) begin
    mv    <= {mv[LAT-2:0], mul_data_rdy};
    mp[0] <= prod;
    for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
  end
  assign mul_res_rdy = (mv[LAT-1] & model_en) | force_rdy;
  assign mul_res     = mp[LAT-1];

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rstn = 1'b1; req_valid = '0; rsp_ack = '0; force_rdy = 1'b0; model_en = 1'b1;
    repeat (n) @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b1; req_valid = '1;
    repeat (6) @(negedge clk);
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    n_vec++; if (rsp_valid !== 4'b0000 || rsp_data !== '0) begin n_err++; $display("FAIL rst_rsp got %b/%h want 0/0", rsp_valid, rsp_data); end
    n_vec++; if (mul_data_rdy !== 1'b0 || mul_mult1 !== '0 || mul_mult2 !== '0) begin n_err++; $display("FAIL rst_mul got %b %h %h want 0 0 0", mul_data_rdy, mul_mult1, mul_mult2); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err); end
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset(6);
    req_a[3:0] = 4'd3; req_b[3:0] = 4'd5; req_valid = 4'b0001;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_gnt got %b want 0001", req_ready); end
    nxt(); req_valid = '0; #1;
    n_vec++; if (mul_data_rdy !== 1'b1 || mul_mult1 !== 4'd3 || mul_mult2 !== 4'd5) begin n_err++; $display("FAIL single_issue got %b %h %h want 1 3 5", mul_data_rdy, mul_mult1, mul_mult2); end
    repeat (4) nxt(); #1;
    n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_early got %b want 0000", rsp_valid); end
    nxt(); #1;
    n_vec++; if (rsp_valid !== 4'b0001 || rsp_data[7:0] !== 8'd15) begin n_err++; $display("FAIL single_rsp got %b %h want 0001 0f", rsp_valid, rsp_data[7:0]); end
    nxt(); #1;
    n_vec++; if (rsp_valid !== 4'b0001 || rsp_data[7:0] !== 8'd15) begin n_err++; $display("FAIL single_hold got %b %h want 0001 0f", rsp_valid, rsp_data[7:0]); end
    req_valid = 4'b0001; rsp_ack = 4'b0001; #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ack_same got %b want 0000", req_ready); end
    nxt(); rsp_ack = '0; #1;
    n_vec++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ack_next got %b/%b want 0000/0001", rsp_valid, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_all_four();
    do_reset(6);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = W'(2);
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_v = (c < 4) ? 4'(1 << c) : 4'b0000;
      n_vec++; if (req_ready !== exp_v) begin n_err++; $display("FAIL all4_gnt c%0d got %b want %b", c, req_ready, exp_v); end
      if (c > 0) begin
        n_vec++; if (mul_data_rdy !== 1'b1 || mul_mult1 !== W'(c)) begin n_err++; $display("FAIL all4_issue c%0d got %b %h want 1 %h", c, mul_data_rdy, mul_mult1, c); end
      end
      if (c == 4) req_valid = '0;
      nxt();
    end
    #1;
    n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL all4_early got %b want 0000", rsp_valid); end
    for (int c = 6; c < 10; c++) begin
      nxt(); #1;
      exp_v = 4'((1 << (c - 5)) - 1);
      n_vec++; if (rsp_valid !== exp_v) begin n_err++; $display("FAIL all4_rspv c%0d got %b want %b", c, rsp_valid, exp_v); end
      n_vec++; if (rsp_data[(c-6)*8 +: 8] !== 8'(2 * (c - 5))) begin n_err++; $display("FAIL all4_data c%0d got %h want %h", c, rsp_data[(c-6)*8 +: 8], 2 * (c - 5)); end
    end
    rsp_ack = 4'b1111;
    nxt(); rsp_ack = '0; #1;
    n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL all4_ack got %b want 0000", rsp_valid); end
`ifdef MSA_PERF_CNT_EN
    n_vec++; if (ops_done !== 16'd4) begin n_err++; $display("FAIL all4_ops got %0d want 4", ops_done); end
`endif
  endtask

  task automatic test_backpressure();
    do_reset(6);
    req_a[7:4] = 4'd2; req_b[7:4] = 4'd7; req_valid = 4'b0010;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_gnt got %b want 0010", req_ready); end
    for (int c = 1; c <= 8; c++) begin
      nxt();
      if (c == 7) req_valid = 4'b0011;
      if (c == 8) rsp_ack = 4'b0010;
      #1;
      exp_v = (c == 7) ? 4'b0001 : 4'b0000;
      n_vec++; if (req_ready !== exp_v) begin n_err++; $display("FAIL bp_hold c%0d got %b want %b", c, req_ready, exp_v); end
      if (c == 6) begin
        n_vec++; if (rsp_valid[1] !== 1'b1 || rsp_data[15:8] !== 8'd14) begin n_err++; $display("FAIL bp_rsp got %b %h want 1 0e", rsp_valid[1], rsp_data[15:8]); end
      end
      if (c == 7) req_valid = 4'b0010;
    end
    nxt(); rsp_ack = '0; #1;
    n_vec++; if (req_ready !== 4'b0010 || rsp_valid[1] !== 1'b0) begin n_err++; $display("FAIL bp_release got %b/%b want 0010/0", req_ready, rsp_valid[1]); end
    req_valid = '0;
  endtask

  task automatic test_rr_fairness();
    do_reset(6);
    req_valid = 4'b0100; #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rr_first got %b want 0100", req_ready); end
    nxt(); req_valid = 4'b1001; #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rr_second got %b want 1000", req_ready); end
    nxt(); #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rr_third got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_midop();
    do_reset(6);
    req_a[3:0] = 4'd3; req_b[3:0] = 4'd5; req_valid = 4'b0001; #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_gnt got %b want 0001", req_ready); end
    nxt(); req_valid = '0;
    nxt();
    nxt(); rstn = 1'b1; req_valid = 4'b1111; #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_rst_gnt got %b want 0000", req_ready); end
    nxt(); rstn = 1'b0; req_valid = '0; #1;
    n_vec++; if (mul_data_rdy !== 1'b0 || mul_mult1 !== '0) begin n_err++; $display("FAIL mid_rst_mul got %b %h want 0 0", mul_data_rdy, mul_mult1); end
    for (int c = 5; c < 10; c++) begin
      nxt(); #1;
      n_vec++; if (rsp_valid !== 4'b0000 || err !== 1'b0) begin n_err++; $display("FAIL mid_late c%0d got %b/%b want 0000/0", c, rsp_valid, err); end
    end
    req_valid = 4'b1111; #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_err();
    do_reset(6);
    repeat (2) nxt();
    #1;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_idle got %b want 0", err); end
    force_rdy = 1'b1;
    nxt(); force_rdy = 1'b0; #1;
    n_vec++; if (err !== 1'b1 || rsp_valid !== 4'b0000) begin n_err++; $display("FAIL err_spurious got %b/%b want 1/0000", err, rsp_valid); end
    repeat (3) nxt();
    #1;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b want 1", err); end
    do_reset(6);
    #1;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", err); end
    model_en = 1'b0; req_valid = 4'b0001; #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL drop_gnt got %b want 0001", req_ready); end
    nxt(); req_valid = '0;
    repeat (5) nxt();
    #1;
    n_vec++; if (err !== 1'b1 || rsp_valid !== 4'b0000) begin n_err++; $display("FAIL drop_err got %b/%b want 1/0000", err, rsp_valid); end
    req_valid = 4'b0001; #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL drop_unbusy got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_rr_fairness();
    test_reset_midop();
    test_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
